// File: rtl/ps2_pkg.sv
// Purpose: shared constants and types for the PS/2 key controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    // Scan-code prefix bytes
    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Pop sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        GAP  = 2'd2
    } pop_state_e;

    // Prefix bytes only modify context and never produce an event
    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Purpose: bundles the keyboard-FIFO side and the key-event side of the controller.
// Latency: n/a (wiring only).
// Backpressure: ev_valid/ev_ack handshake; kb_nextdata_n pops the FIFO.
interface ps2_key_ctrl_if #(
    parameter int CNT_W = 8
);
    // FIFO side
    logic [7:0]       kb_data;
    logic             kb_ready;
    logic             kb_overflow;
    logic             kb_nextdata_n;
    // Event side
    logic             ev_valid;
    logic             ev_ack;
    logic [7:0]       ev_code;
    logic             ev_ext;
    logic             ev_release;
    // Status
    logic             key_down;
    logic [8:0]       held_code;
    logic [CNT_W-1:0] press_cnt;
    logic             ovf_sticky;
    logic             ovf_clr;

    // Controller view
    modport master (
        input  kb_data, kb_ready, kb_overflow, ev_ack, ovf_clr,
        output kb_nextdata_n, ev_valid, ev_code, ev_ext, ev_release,
               key_down, held_code, press_cnt, ovf_sticky
    );

    // Environment view (FIFO + consumer)
    modport slave (
        output kb_data, kb_ready, kb_overflow, ev_ack, ovf_clr,
        input  kb_nextdata_n, ev_valid, ev_code, ev_ext, ev_release,
               key_down, held_code, press_cnt, ovf_sticky
    );

endinterface

// File: rtl/ps2_scan_parser.sv
// Purpose: turns a strobed stream of raw scan bytes into make/break events and held-key state.
// Latency: event registers update on the edge that ends the byte strobe cycle.
// Backpressure: ev_valid holds until ev_ack; caller must not strobe while an event is unaccepted.
module ps2_scan_parser
    import ps2_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_stb,
    input  logic [7:0]       byte_dat,
    input  logic             ev_ack,
    input  logic             kb_overflow,
    input  logic             ovf_clr,
    output logic             ev_valid,
    output logic [7:0]       ev_code,
    output logic             ev_ext,
    output logic             ev_release,
    output logic             key_down,
    output logic [8:0]       held_code,
    output logic [CNT_W-1:0] press_cnt,
    output logic             ovf_sticky
);

    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic             ev_valid_q, ev_valid_d;
    logic [7:0]       ev_code_q, ev_code_d;
    logic             ev_ext_q, ev_ext_d;
    logic             ev_rel_q, ev_rel_d;
    logic             key_down_q, key_down_d;
    logic [8:0]       held_q, held_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [8:0]       key;

    assign key = {ext_q, byte_dat};

    // Prefix accumulation, event generation, held-key tracking and overflow flag
    always_comb begin
        ext_d      = ext_q;
        brk_d      = brk_q;
        ev_valid_d = ev_valid_q;
        ev_code_d  = ev_code_q;
        ev_ext_d   = ev_ext_q;
        ev_rel_d   = ev_rel_q;
        key_down_d = key_down_q;
        held_d     = held_q;
        cnt_d      = cnt_q;

        if (ev_valid_q && ev_ack) begin
            ev_valid_d = 1'b0;
        end

        if (byte_stb) begin
            if (!is_prefix(byte_dat)) begin
                ev_valid_d = 1'b1;
                ev_code_d  = byte_dat;
                ev_ext_d   = ext_q;
                ev_rel_d   = brk_q;
                ext_d      = 1'b0;
                brk_d      = 1'b0;
                if (brk_q) begin
                    // A break only releases the key we believe is held
                    if (held_q == key) begin
                        key_down_d = 1'b0;
                    end
                end else if (!(key_down_q && (held_q == key))) begin
                    // New make (not typematic repeat of the held key)
                    held_d     = key;
                    key_down_d = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end else if (byte_dat == PS2_EXT) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b1;
            end
        end

        // Bytes were lost, so any half-built prefix context is meaningless
        if (kb_overflow) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        // Set dominates clear so an overflow is never missed
        if (kb_overflow) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            ev_valid_q <= 1'b0;
            ev_code_q  <= 8'h00;
            ev_ext_q   <= 1'b0;
            ev_rel_q   <= 1'b0;
            key_down_q <= 1'b0;
            held_q     <= 9'h000;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            ev_valid_q <= ev_valid_d;
            ev_code_q  <= ev_code_d;
            ev_ext_q   <= ev_ext_d;
            ev_rel_q   <= ev_rel_d;
            key_down_q <= key_down_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_code    = ev_code_q;
    assign ev_ext     = ev_ext_q;
    assign ev_release = ev_rel_q;
    assign key_down   = key_down_q;
    assign held_code  = held_q;
    assign press_cnt  = cnt_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: rtl/ps2_key_ctrl.sv
// Purpose: pops the PS/2 scan-code FIFO and feeds bytes to the scan parser.
// Latency: kb_ready sampled at edge N, pop strobe low N..N+1, event valid after N+1; 1 byte per 2+GAP_CYC cycles.
// Backpressure: no pop starts while an event is valid and not being acked this cycle.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int GAP_CYC = 1
) (
    input  logic           clk,
    input  logic           rst,
    ps2_key_ctrl_if.master bus
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    pop_state_e       state_q, state_d;
    logic [7:0]       byte_q, byte_d;
    logic             nextdata_n_q, nextdata_n_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             ev_busy;
    logic             byte_stb;

    // An event still waiting for its ack blocks the next pop
    assign ev_busy  = bus.ev_valid && !bus.ev_ack;
    // The popped byte is handed to the parser for exactly the POP cycle
    assign byte_stb = (state_q == POP);

    // Pop sequencer next state: IDLE waits for data, POP strobes, GAP lets the FIFO settle
    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        nextdata_n_d = 1'b1;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.kb_ready && !ev_busy) begin
                    state_d      = POP;
                    byte_d       = bus.kb_data;
                    nextdata_n_d = 1'b0;
                end
            end
            POP: begin
                state_d   = GAP;
                gap_cnt_d = GAP_W'(GAP_CYC - 1);
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pop sequencer registers; reset releases the pop strobe immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_q       <= 8'h00;
            nextdata_n_q <= 1'b1;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            nextdata_n_q <= nextdata_n_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign bus.kb_nextdata_n = nextdata_n_q;

    ps2_scan_parser #(
        .CNT_W (CNT_W)
    ) u_parser (
        .clk         (clk),
        .rst         (rst),
        .byte_stb    (byte_stb),
        .byte_dat    (byte_q),
        .ev_ack      (bus.ev_ack),
        .kb_overflow (bus.kb_overflow),
        .ovf_clr     (bus.ovf_clr),
        .ev_valid    (bus.ev_valid),
        .ev_code     (bus.ev_code),
        .ev_ext      (bus.ev_ext),
        .ev_release  (bus.ev_release),
        .key_down    (bus.key_down),
        .held_code   (bus.held_code),
        .press_cnt   (bus.press_cnt),
        .ovf_sticky  (bus.ovf_sticky)
    );

endmodule
